// File: rtl/cic_pdm_decim_if.sv
// Stream bundle between the PDM front end, the CIC decimator and hb1.
// Latency: none, wires only.
// Backpressure: none; there is no ready, so the consumer must take every strobe.
interface cic_pdm_decim_if #(
    parameter int OUT_W = 16
);
    logic                    pdm_in;
    logic                    pdm_valid;
    logic signed [OUT_W-1:0] y_out;
    logic                    y_out_valid;

    // Upstream side: drives PDM bits and observes PCM samples.
    modport master (
        output pdm_in,
        output pdm_valid,
        input  y_out,
        input  y_out_valid
    );

    // Decimator side: consumes PDM bits and produces PCM samples.
    modport slave (
        input  pdm_in,
        input  pdm_valid,
        output y_out,
        output y_out_valid
    );
endinterface

// File: rtl/cic_pdm_decim.sv
// Nth-order CIC decimator: 1-bit PDM in, signed OUT_W-bit PCM out every R accepted bits.
// Latency: y_out_valid pulses 1 clk after the R-th accepted bit of each group.
// Backpressure: none; pdm_valid gaps stall every stage, and output strobes cannot be held off.
module cic_pdm_decim #(
    parameter int R     = 12,
    parameter int N     = 4,
    parameter int W     = 18,
    parameter int OUT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    cic_pdm_decim_if.slave  bus
);
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    logic [CW-1:0]         cnt_q;
    logic                  strobe;
    logic signed [W-1:0]   x_map;
    logic signed [W-1:0]   integ_q    [N];
    logic signed [W-1:0]   integ_d    [N];
    logic signed [W-1:0]   comb_dly_q [N];
    logic signed [W-1:0]   comb_out   [N];
    logic signed [OUT_W-1:0] y_q;
    logic                  y_vld_q;

    // Decimation strobe fires on the accepted bit that closes a group of R.
    assign strobe = bus.pdm_valid && (cnt_q == CW'(R - 1));

    // Bit 1 -> +1, bit 0 -> -1, both as W-bit two's complement.
    assign x_map = bus.pdm_in ? W'(1) : {W{1'b1}};

    // Integrator next-state and comb differences; all arithmetic wraps modulo 2^W by design.
    always_comb begin
        integ_d[0] = integ_q[0] + x_map;
        for (int k = 1; k < N; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        comb_out[0] = integ_d[N-1] - comb_dly_q[0];
        for (int k = 1; k < N; k++) begin
            comb_out[k] = comb_out[k-1] - comb_dly_q[k];
        end
    end

    // Integrators and the group counter advance only on accepted bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= '0;
            end
        end else if (bus.pdm_valid) begin
            cnt_q <= strobe ? '0 : cnt_q + CW'(1);
            for (int k = 0; k < N; k++) begin
                integ_q[k] <= integ_d[k];
            end
        end
    end

    // Comb delays and the output register update at the decimated rate only.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q     <= '0;
            y_vld_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                comb_dly_q[k] <= '0;
            end
        end else begin
            y_vld_q <= strobe;
            if (strobe) begin
                comb_dly_q[0] <= integ_d[N-1];
                for (int k = 1; k < N; k++) begin
                    comb_dly_q[k] <= comb_out[k-1];
                end
                // Gain R^N fits in OUT_W signed for the intended configuration, so plain truncation.
                y_q <= comb_out[N-1][OUT_W-1:0];
            end
        end
    end

    assign bus.y_out       = y_q;
    assign bus.y_out_valid = y_vld_q;
endmodule

// File: tb/tb_cic_pdm_decim.sv
// Directed bench for cic_pdm_decim with hand-derived expected PCM values.
// Latency: checks first pulse at 12 clks after the first valid bit, 24 with half-rate valid.
// Backpressure: none to exercise; pdm_valid gaps and mid-group reset are driven directly.
module tb_cic_pdm_decim;
    localparam int OUT_W = 16;
    localparam int FULL  = 20736;

    logic clk;
    logic reset;
    int   n_asrt;
    int   n_fail;
    int   pv [$];
    int   pc [$];
    int   hold_err;
    int   step_exp [4];
    int   prev;

    cic_pdm_decim_if #(.OUT_W(OUT_W)) bus ();

    cic_pdm_decim #(.R(12), .N(4), .W(18), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic d);
        reset         = r;
        bus.pdm_valid = v;
        bus.pdm_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // mode 0: all ones, 1: all zeros, 2: alternating 1,0 over accepted bits.
    task automatic run(input int n, input int mode, input bit gaps);
        int   nvalid;
        int   last;
        logic v;
        logic d;
        nvalid   = 0;
        hold_err = 0;
        last     = int'($signed(bus.y_out));
        pv.delete();
        pc.delete();
        for (int i = 0; i < n; i++) begin
            v = gaps ? ((i % 2) == 0) : 1'b1;
            case (mode)
                0:       d = 1'b1;
                1:       d = 1'b0;
                default: d = ((nvalid % 2) == 0);
            endcase
            step(1'b0, v, d);
            if (v) nvalid++;
            if (bus.y_out_valid === 1'b1) begin
                pv.push_back(int'($signed(bus.y_out)));
                pc.push_back(i + 1);
                last = int'($signed(bus.y_out));
            end else if (int'($signed(bus.y_out)) != last) begin
                hold_err++;
            end
        end
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        step_exp = '{495, 8646, 19371, 20736};
        bus.pdm_in    = 1'b0;
        bus.pdm_valid = 1'b0;
        reset         = 1'b1;

        // Reset state.
        do_reset();
        chk("reset_y_out", $signed(bus.y_out), 0);
        chk("reset_y_vld", {31'd0, bus.y_out_valid}, 0);

        // Step response, all ones.
        run(600, 0, 1'b0);
        chk("ones_count", pv.size(), 50);
        chk("ones_hold", hold_err, 0);
        prev = -100000;
        for (int k = 0; k < pv.size(); k++) begin
            chk("ones_cycle", pc[k], 12 * (k + 1));
            chk("ones_value", pv[k], (k < 4) ? step_exp[k] : FULL);
            chk("ones_monotonic", (pv[k] >= prev) ? 1 : 0, 1);
            prev = pv[k];
        end

        // All zeros.
        do_reset();
        run(600, 1, 1'b0);
        chk("zeros_count", pv.size(), 50);
        for (int k = 0; k < pv.size(); k++) begin
            chk("zeros_value", pv[k], (k < 4) ? -step_exp[k] : -FULL);
        end

        // Alternating 50 % density.
        do_reset();
        run(600, 2, 1'b0);
        chk("alt_count", pv.size(), 50);
        for (int k = 4; k < pv.size(); k++) begin
            chk("alt_value", pv[k], 0);
        end

        // Rate: 1200 bits with valid tied high.
        do_reset();
        run(1200, 0, 1'b0);
        chk("rate_count", pv.size(), 100);
        chk("rate_ratio_x100", (pv.size() == 0) ? 0 : (1200 * 100) / pv.size(), 1200);

        // pdm_valid low every other cycle.
        do_reset();
        run(1200, 0, 1'b1);
        chk("gap_count", pv.size(), 50);
        chk("gap_hold", hold_err, 0);
        for (int k = 0; k < pv.size(); k++) begin
            chk("gap_cycle", pc[k], 24 * (k + 1) - 1);
            chk("gap_value", pv[k], (k < 4) ? step_exp[k] : FULL);
        end

        // Reset for one cycle at bit 7 of the third group of an all-ones stream.
        do_reset();
        run(31, 0, 1'b0);
        chk("mid_pre_count", pv.size(), 2);
        chk("mid_pre_y_out", $signed(bus.y_out), 8646);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_rst_y_out", $signed(bus.y_out), 0);
        chk("mid_rst_y_vld", {31'd0, bus.y_out_valid}, 0);
        run(36, 0, 1'b0);
        chk("mid_post_count", pv.size(), 3);
        for (int k = 0; k < pv.size(); k++) begin
            chk("mid_post_cycle", pc[k], 12 * (k + 1));
            chk("mid_post_value", pv[k], step_exp[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
